conv_layer_seq: RTL and testbench
=================================

// Module: conv_layer_seq
// PURPOSE
//  Sequencer for one 9x9 conv-layer engine. Its single job is to move one full feature map through the engine.
//  - Input side: on a go pulse it streams the 96x96 input map from the input BRAM into the engine.
//  - Engine control: drives the engine's clear and start lines.
//  - Output side: packs the 88x88 valid results (engine save strobes) into a linear output buffer.
//  - Finish: reports done, or err on timeout or count mismatch.
//  Sits between the layer-input BRAM, the conv engine and the pooling-stage input buffer.
// PARAMETERS
//  NUM_IN     14'd9216  input pixels per map (96*96)
//  NUM_OUT    13'd7744  results per map (88*88)
//  START_OFS  14'd868   cycles from first pixel at conv_map_in to conv_start rise (864 window fill + 4 pipe)
//  TIMEOUT    16'd2048  max DRAIN cycles before err
// PORTS
//  clk_in        in   1   clock, all logic rising-edge
//  rst_n         in   1   async reset, active-low
//  go            in   1   start pulse; sampled only in IDLE
//  busy          out  1   high in FEED/DRAIN
//  done          out  1   1-cycle pulse at end of map (success or error)
//  err           out  1   sticky: timeout or engine ready mismatch; cleared by next accepted go
//  in_rd         out  1   input BRAM read enable
//  in_addr       out  14  input BRAM address
//  in_data       in   16  input BRAM data, valid 1 cycle after in_rd
//  conv_clr      out  1   engine clear, active-high
//  conv_start    out  1   engine start/ce
//  conv_map_in   out  16  pixel to engine (signed)
//  conv_map_out  in   16  engine result (signed)
//  conv_save     in   1   engine result-valid strobe
//  conv_ready    in   1   engine ready (falls when engine has emitted NUM_OUT)
//  out_we        out  1   output buffer write enable
//  out_addr      out  13  output buffer address
//  out_data      out  16  output buffer data
// BEHAVIOUR
//  Reset values: state=IDLE; busy=done=err=in_rd=conv_start=out_we=0; conv_clr=1; all addr/data/counters=0.
//  FSM: IDLE -> FEED -> DRAIN -> FIN -> IDLE.
//  IDLE
//   - conv_clr=1.
//   - go=1: clear err, feed_cnt and out_cnt; go to FEED.
//  FEED
//   - conv_clr=0, in_rd=1, in_addr=feed_cnt, feed_cnt+1 per cycle.
//   - conv_map_in <= in_data (registered), so pixel k reaches the engine 2 cycles after address k is issued.
//   - Leave after address NUM_IN-1 is issued; go to DRAIN.
//  DRAIN
//   - in_rd=0; conv_map_in=0 from the cycle after the last valid pixel.
//   - drain_cnt+1 per cycle.
//  Start control: conv_start rises when first-pixel-relative count == START_OFS (FEED or DRAIN); stays high until FIN.
//  Output path, 1-cycle registered:
//   - out_we <= conv_save & conv_start & (out_cnt<NUM_OUT).
//   - out_data <= conv_map_out; out_addr <= out_cnt.
//   - out_cnt+1 per write; saturates at NUM_OUT; extra saves are dropped.
//  Success: out_cnt==NUM_OUT -> FIN.
//  Errors (all -> FIN with err=1):
//   - drain_cnt==TIMEOUT with out_cnt<NUM_OUT.
//   - conv_ready=0 while out_cnt<NUM_OUT-1 and conv_start=1.
//  FIN: one cycle; done=1, conv_start=0, conv_clr=1; next state IDLE.
//  busy=1 in FEED/DRAIN only. go while busy or in FIN is ignored, not queued.
//  Simultaneous last write and timeout in the same cycle: success wins, err=0.
//  Async rst_n low mid-map: immediately return to reset values. A partially written output buffer is not invalidated; no done.
//  Widths: feed_cnt 14b, out_cnt 13b, drain_cnt 16b; no wrap (FSM exits before limits).
// TESTING
//  1 Reset: rst_n=0 mid-FEED at addr 500 -> next cycle in_rd=0, busy=0, conv_clr=1, out_we=0, state IDLE.
//  2 Nominal map: BRAM[k]=k, model engine asserts 7744 saves -> addr 0..9215 each once; out_addr 0..7743; done 1 cycle; err=0.
//  3 Start timing: go at t0 -> in_addr=0 at t0+1, conv_map_in=BRAM[0] at t0+3, conv_start rises at t0+3+868.
//  4 Timeout: model stops saves after 100 -> err=1 and done exactly 2048 cycles into DRAIN; out_cnt=100.
//  5 Overflow/ignore: 7750 saves -> exactly 7744 writes; go pulsed while busy -> no restart; second go after done -> full rerun, err cleared.
//  6 Ready mismatch: conv_ready=0 after 4000 writes -> err=1, done pulse, return to IDLE.

Source files
------------

// File: rtl/conv_layer_seq.sv
// Sequencer that streams one 96x96 map into a 9x9 conv engine
// and packs the engine's 88x88 results into a linear buffer.
module conv_layer_seq (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        go,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        in_rd,
  output logic [13:0] in_addr,
  input  logic [15:0] in_data,
  output logic        conv_clr,
  output logic        conv_start,
  output logic [15:0] conv_map_in,
  input  logic [15:0] conv_map_out,
  input  logic        conv_save,
  input  logic        conv_ready,
  output logic        out_we,
  output logic [12:0] out_addr,
  output logic [15:0] out_data
);

  localparam logic [13:0] NUM_IN    = 14'd9216;
  localparam logic [12:0] NUM_OUT   = 13'd7744;
  localparam logic [13:0] START_OFS = 14'd868;
  localparam logic [15:0] TIMEOUT   = 16'd2048;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FEED  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [13:0] feed_cnt_q, feed_cnt_d;
  logic [12:0] out_cnt_q, out_cnt_d;
  logic [15:0] drain_cnt_q, drain_cnt_d;
  logic        rd_q, rd_d;
  logic        start_q, start_d;
  logic        err_q, err_d;
  logic [15:0] map_q, map_d;
  logic        we_q, we_d;
  logic [12:0] oaddr_q, oaddr_d;
  logic [15:0] odata_q, odata_d;

  logic wr, succ, tmo, mis, run;

  always_comb begin
    state_d     = state_q;
    feed_cnt_d  = feed_cnt_q;
    out_cnt_d   = out_cnt_q;
    drain_cnt_d = drain_cnt_q;
    start_d     = start_q;
    err_d       = err_q;
    rd_d        = (state_q == S_FEED);
    map_d       = rd_q ? in_data : 16'd0;

    wr      = conv_save & start_q & (out_cnt_q < NUM_OUT);
    we_d    = wr;
    oaddr_d = out_cnt_q;
    odata_d = conv_map_out;
    if (wr) out_cnt_d = out_cnt_q + 13'd1;

    run  = (state_q == S_FEED) | (state_q == S_DRAIN);
    succ = (out_cnt_q == NUM_OUT);
    tmo  = (state_q == S_DRAIN) & (drain_cnt_q == TIMEOUT);
    mis  = ~conv_ready & start_q & (out_cnt_q < NUM_OUT - 13'd1);

    case (state_q)
      S_IDLE: begin
        if (go) begin
          err_d       = 1'b0;
          feed_cnt_d  = 14'd0;
          out_cnt_d   = 13'd0;
          drain_cnt_d = 16'd0;
          state_d     = S_FEED;
        end
      end
      S_FEED: begin
        feed_cnt_d = feed_cnt_q + 14'd1;
        // set one cycle early so the rise lands START_OFS after pixel 0
        if (feed_cnt_q == START_OFS + 14'd1) start_d = 1'b1;
        if (feed_cnt_q == NUM_IN - 14'd1) begin
          drain_cnt_d = 16'd1;
          state_d     = S_DRAIN;
        end
      end
      S_DRAIN: drain_cnt_d = drain_cnt_q + 16'd1;
      default: state_d = S_IDLE;
    endcase

    if (run) begin
      // success outranks a same-cycle timeout or ready drop
      if (succ) begin
        state_d = S_FIN;
        start_d = 1'b0;
      end else if (tmo | mis) begin
        state_d = S_FIN;
        start_d = 1'b0;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      feed_cnt_q  <= 14'd0;
      out_cnt_q   <= 13'd0;
      drain_cnt_q <= 16'd0;
      rd_q        <= 1'b0;
      start_q     <= 1'b0;
      err_q       <= 1'b0;
      map_q       <= 16'd0;
      we_q        <= 1'b0;
      oaddr_q     <= 13'd0;
      odata_q     <= 16'd0;
    end else begin
      state_q     <= state_d;
      feed_cnt_q  <= feed_cnt_d;
      out_cnt_q   <= out_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      rd_q        <= rd_d;
      start_q     <= start_d;
      err_q       <= err_d;
      map_q       <= map_d;
      we_q        <= we_d;
      oaddr_q     <= oaddr_d;
      odata_q     <= odata_d;
    end
  end

  assign busy        = (state_q == S_FEED) | (state_q == S_DRAIN);
  assign done        = (state_q == S_FIN);
  assign err         = err_q;
  assign in_rd       = (state_q == S_FEED);
  assign in_addr     = in_rd ? feed_cnt_q : 14'd0;
  assign conv_clr    = (state_q == S_IDLE) | (state_q == S_FIN);
  assign conv_start  = start_q;
  assign conv_map_in = map_q;
  assign out_we      = we_q;
  assign out_addr    = oaddr_q;
  assign out_data    = odata_q;

endmodule

// File: tb/tb_conv_layer_seq.sv
// Bench for conv_layer_seq: a cycle-level engine/BRAM model
// drives random maps and scores the output buffer writes.
module tb_conv_layer_seq;

  localparam int NIN  = 9216;
  localparam int NOUT = 7744;
  localparam int BIG  = 1000000;

  logic        clk_in = 1'b0;
  logic        rst_n  = 1'b0;
  logic        go     = 1'b0;
  logic        busy, done, err, in_rd;
  logic [13:0] in_addr;
  logic [15:0] in_data = 16'd0;
  logic        conv_clr, conv_start;
  logic [15:0] conv_map_in;
  logic [15:0] conv_map_out = 16'd0;
  logic        conv_save = 1'b0;
  logic        conv_ready = 1'b1;
  logic        out_we;
  logic [12:0] out_addr;
  logic [15:0] out_data;

  conv_layer_seq dut (
    .clk_in(clk_in), .rst_n(rst_n), .go(go),
    .busy(busy), .done(done), .err(err),
    .in_rd(in_rd), .in_addr(in_addr), .in_data(in_data),
    .conv_clr(conv_clr), .conv_start(conv_start),
    .conv_map_in(conv_map_in), .conv_map_out(conv_map_out),
    .conv_save(conv_save), .conv_ready(conv_ready),
    .out_we(out_we), .out_addr(out_addr), .out_data(out_data)
  );

  always #5 clk_in = ~clk_in;

  int n_chk = 0;
  int n_pass = 0;

  logic [15:0] bram [0:NIN-1];
  int          seen [0:NIN-1];
  logic [15:0] exp_q [$];

  int r_writes, r_wbad, r_abad, r_mapbad, r_miss;
  int r_done_cnt, r_done_c, r_first_rd, r_first_pix, r_start_c;
  int r_err_c1, r_err_done, r_hung;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  task automatic run_map(input int save_lim, input int drop_at,
                         input int go_again, input bit rnd);
    int c, rd_n, acc, emitted, sj;
    bit rd1, rd2, save;
    int a1, a2;
    logic [15:0] em;
    for (int k = 0; k < NIN; k++) begin
      bram[k] = rnd ? 16'($urandom) : 16'(k);
      seen[k] = 0;
    end
    exp_q.delete();
    r_writes = 0; r_wbad = 0; r_abad = 0; r_mapbad = 0; r_miss = 0;
    r_done_cnt = 0; r_done_c = -1; r_first_rd = -1; r_first_pix = -1;
    r_start_c = -1; r_err_c1 = -1; r_err_done = -1; r_hung = 0;
    rd_n = 0; acc = 0; emitted = 0; sj = 0;
    rd1 = 0; rd2 = 0; a1 = 0; a2 = 0;
    @(negedge clk_in);
    go = 1'b1;
    c = 0;
    forever begin
      @(negedge clk_in);
      c++;
      go = (c == go_again);
      in_data = rd1 ? bram[a1] : 16'($urandom);
      em = rd2 ? bram[a2] : 16'd0;
      if (conv_map_in !== em) r_mapbad++;
      if (rd2 && a2 == 0 && r_first_pix < 0) r_first_pix = c;
      rd2 = rd1; a2 = a1;
      rd1 = in_rd; a1 = int'(in_addr);
      if (in_rd) begin
        seen[in_addr]++;
        if (r_first_rd < 0) r_first_rd = c;
        if (int'(in_addr) != rd_n) r_abad++;
        rd_n++;
      end
      if (c == 1) r_err_c1 = int'(err);
      if (out_we) begin
        if (r_writes >= exp_q.size() || int'(out_addr) != r_writes ||
            out_data !== exp_q[r_writes]) r_wbad++;
        r_writes++;
      end
      if (done) begin
        r_done_cnt++;
        r_done_c = c;
        r_err_done = int'(err);
      end
      conv_ready = (acc < drop_at);
      conv_map_out = 16'($urandom);
      save = 1'b0;
      if (conv_start) begin
        if (r_start_c < 0) r_start_c = c;
        save = conv_ready && emitted < save_lim && (sj % 96) < 88;
        sj++;
        if (save) begin
          emitted++;
          if (acc < NOUT) begin
            exp_q.push_back(conv_map_out);
            acc++;
          end
        end
        conv_save = save;
      end else begin
        conv_save = 1'($urandom);
      end
      if (r_done_c > 0 && c >= r_done_c + 2) break;
      if (c > 20000) begin
        r_hung = 1;
        break;
      end
    end
    go = 1'b0;
    conv_save = 1'b0;
    conv_ready = 1'b1;
    for (int k = 0; k < NIN; k++) if (seen[k] != 1) r_miss++;
  endtask

  initial begin
    conv_ready = 1'b1;
    repeat (3) @(negedge clk_in);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_in_rd", in_rd, 0);
    chk("rst_start", conv_start, 0);
    chk("rst_out_we", out_we, 0);
    chk("rst_clr", conv_clr, 1);
    chk("rst_addrs", {in_addr, out_addr}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_in);

    // nominal map, BRAM[k]=k
    run_map(NOUT, NOUT, -1, 1'b0);
    chk("nom_hung", r_hung, 0);
    chk("nom_first_rd", r_first_rd, 1);
    chk("nom_first_pix", r_first_pix, 3);
    chk("nom_start_rise", r_start_c, 3 + 868);
    chk("nom_map_in", r_mapbad, 0);
    chk("nom_addr_seq", r_abad, 0);
    chk("nom_addr_once", r_miss, 0);
    chk("nom_writes", r_writes, NOUT);
    chk("nom_wr_bad", r_wbad, 0);
    chk("nom_done_cnt", r_done_cnt, 1);
    chk("nom_err", r_err_done, 0);
    chk("nom_busy_after", busy, 0);
    chk("nom_clr_after", conv_clr, 1);

    // extra saves plus a go while busy
    run_map(NOUT + 6, BIG, 5000, 1'b1);
    chk("ovf_hung", r_hung, 0);
    chk("ovf_writes", r_writes, NOUT);
    chk("ovf_wr_bad", r_wbad, 0);
    chk("ovf_addr_seq", r_abad, 0);
    chk("ovf_addr_once", r_miss, 0);
    chk("ovf_done_cnt", r_done_cnt, 1);
    chk("ovf_err", r_err_done, 0);
    chk("ovf_map_in", r_mapbad, 0);

    // engine stalls after 100 results
    run_map(100, BIG, -1, 1'b1);
    chk("tmo_hung", r_hung, 0);
    chk("tmo_done_c", r_done_c, 1 + NIN + 2048);
    chk("tmo_err", r_err_done, 1);
    chk("tmo_writes", r_writes, 100);
    chk("tmo_wr_bad", r_wbad, 0);
    chk("tmo_done_cnt", r_done_cnt, 1);
    repeat (5) @(negedge clk_in);
    chk("tmo_err_sticky", err, 1);

    // rerun after error clears err
    run_map(NOUT, NOUT, -1, 1'b1);
    chk("rerun_err_c1", r_err_c1, 0);
    chk("rerun_writes", r_writes, NOUT);
    chk("rerun_wr_bad", r_wbad, 0);
    chk("rerun_addr_once", r_miss, 0);
    chk("rerun_err", r_err_done, 0);
    chk("rerun_map_in", r_mapbad, 0);

    // ready drops after 4000 results
    run_map(NOUT, 4000, -1, 1'b1);
    chk("mis_hung", r_hung, 0);
    chk("mis_err", r_err_done, 1);
    chk("mis_done_cnt", r_done_cnt, 1);
    chk("mis_writes", r_writes, 4000);
    chk("mis_wr_bad", r_wbad, 0);
    chk("mis_idle", busy, 0);

    // async reset mid-feed at address 500
    @(negedge clk_in);
    go = 1'b1;
    @(negedge clk_in);
    go = 1'b0;
    begin
      int w;
      w = 0;
      while (!(in_rd && in_addr == 14'd500) && w < 1000) begin
        @(negedge clk_in);
        w++;
      end
      chk("arst_reach500", int'(w < 1000), 1);
    end
    rst_n = 1'b0;
    #1;
    chk("arst_in_rd", in_rd, 0);
    chk("arst_busy", busy, 0);
    chk("arst_clr", conv_clr, 1);
    chk("arst_out_we", out_we, 0);
    chk("arst_done", done, 0);
    @(negedge clk_in);
    chk("arst_hold", {in_rd, busy, done, conv_start}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_in);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
